// File: rtl/cache_pkg.sv
// Shared types, default geometry and tree-PLRU helpers for set_assoc_cache.
// Helpers work on the widest supported tree (8 ways); callers pass the level count.
package cache_pkg;

   localparam int unsigned DEF_S_OFFSET  = 5;
   localparam int unsigned DEF_S_INDEX   = 3;
   localparam int unsigned DEF_S_WAYS    = 2;
   localparam int unsigned PLRU_MAX_BITS = 7;
   localparam int unsigned WAY_MAX_BITS  = 3;

   typedef enum logic [1:0] {
      CHECK,
      WRITEBACK,
      FILL
   } cache_state_e;

   // Walk from the root: a 0 bit points at the lower half, 1 at the upper half.
   function automatic logic [WAY_MAX_BITS-1:0] plru_victim(
      input logic [PLRU_MAX_BITS-1:0] bits,
      input int unsigned              levels
   );
      logic [WAY_MAX_BITS-1:0] way;
      logic [2:0]              node;
      way  = '0;
      node = '0;
      for (int unsigned lvl = 0; lvl < WAY_MAX_BITS; lvl++) begin
         if (lvl < levels) begin
            way  = {way[1:0], bits[node]};
            node = {node[1:0], 1'b0} + (bits[node] ? 3'd2 : 3'd1);
         end
      end
      return way;
   endfunction

   // Every node on the accessed way's path is set to point away from it.
   function automatic logic [PLRU_MAX_BITS-1:0] plru_update(
      input logic [PLRU_MAX_BITS-1:0] bits,
      input logic [WAY_MAX_BITS-1:0]  way,
      input int unsigned              levels
   );
      logic [PLRU_MAX_BITS-1:0] nxt;
      logic [2:0]               node;
      logic [WAY_MAX_BITS-1:0]  w;
      nxt  = bits;
      node = '0;
      w    = way << (WAY_MAX_BITS - levels);
      for (int unsigned lvl = 0; lvl < WAY_MAX_BITS; lvl++) begin
         if (lvl < levels) begin
            nxt[node] = ~w[2];
            node      = {node[1:0], 1'b0} + (w[2] ? 3'd2 : 3'd1);
            w         = w << 1;
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Line-granular request/response bus, used on both the CPU and the memory side of the cache.
interface set_assoc_cache_if #(
   parameter int unsigned s_mask = 32
);
   localparam int unsigned s_line = 8 * s_mask;

   logic              read;
   logic              write;
   logic [31:0]       address;
   logic [s_mask-1:0] byte_enable;
   logic [s_line-1:0] wdata;
   logic [s_line-1:0] rdata;
   logic              resp;

   modport master (
      output read, write, address, byte_enable, wdata,
      input  rdata, resp
   );

   modport slave (
      input  read, write, address, byte_enable, wdata,
      output rdata, resp
   );

endinterface

// File: rtl/cache_plru.sv
// Combinational tree-PLRU for one set: victim way from the current bits, and the
// bits that result from an access to access_way.
module cache_plru
   import cache_pkg::*;
#(
   parameter int unsigned s_ways = DEF_S_WAYS
) (
   input  logic [(1 << s_ways)-2:0] plru_bits,
   input  logic [s_ways-1:0]        access_way,
   output logic [s_ways-1:0]        victim_way,
   output logic [(1 << s_ways)-2:0] plru_next
);

   localparam int unsigned n_nodes = (1 << s_ways) - 1;

   logic [PLRU_MAX_BITS-1:0] bits_ext;
   logic [PLRU_MAX_BITS-1:0] next_ext;
   logic [WAY_MAX_BITS-1:0]  way_ext;
   logic [WAY_MAX_BITS-1:0]  victim_ext;

   always_comb begin
      bits_ext   = PLRU_MAX_BITS'(plru_bits);
      way_ext    = WAY_MAX_BITS'(access_way);
      victim_ext = plru_victim(bits_ext, s_ways);
      next_ext   = plru_update(bits_ext, way_ext, s_ways);
   end

   assign victim_way = s_ways'(victim_ext);
   assign plru_next  = n_nodes'(next_ext);

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with tree-PLRU and miss FSM.
// Define CACHE_PERF_CTR_EN to build the hit/miss/writeback counters.
module set_assoc_cache
   import cache_pkg::*;
#(
   parameter int unsigned s_offset = DEF_S_OFFSET,
   parameter int unsigned s_index  = DEF_S_INDEX,
   parameter int unsigned s_ways   = DEF_S_WAYS
) (
   input  logic              clk,
   input  logic              rst_n,
   set_assoc_cache_if.slave  mem,
   set_assoc_cache_if.master pmem,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
   output logic [31:0]       wb_count
);

   localparam int unsigned s_mask  = 1 << s_offset;
   localparam int unsigned s_line  = 8 * s_mask;
   localparam int unsigned s_tag   = 32 - s_offset - s_index;
   localparam int unsigned n_sets  = 1 << s_index;
   localparam int unsigned n_ways  = 1 << s_ways;
   localparam int unsigned n_nodes = n_ways - 1;

   logic [s_line-1:0]  data_q  [n_sets][n_ways];
   logic [s_line-1:0]  data_d  [n_sets][n_ways];
   logic [s_tag-1:0]   tag_q   [n_sets][n_ways];
   logic [s_tag-1:0]   tag_d   [n_sets][n_ways];
   logic [n_ways-1:0]  valid_q [n_sets];
   logic [n_ways-1:0]  valid_d [n_sets];
   logic [n_ways-1:0]  dirty_q [n_sets];
   logic [n_ways-1:0]  dirty_d [n_sets];
   logic [n_nodes-1:0] plru_q  [n_sets];
   logic [n_nodes-1:0] plru_d  [n_sets];

   cache_state_e      state_q, state_d;
   logic [s_ways-1:0] victim_q, victim_d;
   logic              pmem_read_q, pmem_read_d;
   logic              pmem_write_q, pmem_write_d;

   logic [s_tag-1:0]   req_tag;
   logic [s_index-1:0] req_index;
   logic               req;
   logic               hit;
   logic [s_ways-1:0]  hit_way;
   logic               inv_found;
   logic [s_ways-1:0]  inv_way;
   logic [s_ways-1:0]  plru_way;
   logic [s_ways-1:0]  way_sel;
   logic [n_nodes-1:0] plru_hit_next;
   logic               mem_resp_c;
   logic               hit_evt, fill_evt, wb_evt;
   logic               unused_offset;

   assign req_tag       = mem.address[31 -: s_tag];
   assign req_index     = mem.address[s_offset +: s_index];
   assign unused_offset = ^mem.address[s_offset-1:0];
   assign req           = mem.read | mem.write;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int unsigned w = 0; w < n_ways; w++) begin
         if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
            hit     = 1'b1;
            hit_way = s_ways'(w);
         end
         if (!valid_q[req_index][w] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = s_ways'(w);
         end
      end
   end

   cache_plru #(
      .s_ways(s_ways)
   ) u_plru (
      .plru_bits (plru_q[req_index]),
      .access_way(hit_way),
      .victim_way(plru_way),
      .plru_next (plru_hit_next)
   );

   assign way_sel = inv_found ? inv_way : plru_way;

   always_comb begin
      data_d     = data_q;
      tag_d      = tag_q;
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      plru_d     = plru_q;
      state_d    = state_q;
      victim_d   = victim_q;
      mem_resp_c = 1'b0;
      hit_evt    = 1'b0;
      fill_evt   = 1'b0;
      wb_evt     = 1'b0;
      case (state_q)
         CHECK: begin
            if (req) begin
               if (hit) begin
                  mem_resp_c                = 1'b1;
                  hit_evt                   = 1'b1;
                  plru_d[req_index]         = plru_hit_next;
                  if (mem.write) begin
                     for (int unsigned b = 0; b < s_mask; b++) begin
                        if (mem.byte_enable[b]) begin
                           data_d[req_index][hit_way][8*b +: 8] = mem.wdata[8*b +: 8];
                        end
                     end
                     dirty_d[req_index][hit_way] = 1'b1;
                  end
               end else begin
                  victim_d = way_sel;
                  if (valid_q[req_index][way_sel] && dirty_q[req_index][way_sel]) begin
                     state_d = WRITEBACK;
                     wb_evt  = 1'b1;
                  end else begin
                     state_d  = FILL;
                     fill_evt = 1'b1;
                  end
               end
            end
         end
         WRITEBACK: begin
            if (pmem.resp) begin
               dirty_d[req_index][victim_q] = 1'b0;
               state_d                      = FILL;
               fill_evt                     = 1'b1;
            end
         end
         FILL: begin
            if (pmem.resp) begin
               data_d[req_index][victim_q]  = pmem.rdata;
               tag_d[req_index][victim_q]   = req_tag;
               valid_d[req_index][victim_q] = 1'b1;
               dirty_d[req_index][victim_q] = 1'b0;
               state_d                      = CHECK;
            end
         end
         default: state_d = CHECK;
      endcase
      pmem_read_d  = (state_d == FILL);
      pmem_write_d = (state_d == WRITEBACK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CHECK;
         victim_q     <= '0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         valid_q      <= '{default: '0};
         dirty_q      <= '{default: '0};
         plru_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         victim_q     <= victim_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         plru_q       <= plru_d;
      end
   end

   // Line data and tags are qualified by valid bits, so they need no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
      tag_q  <= tag_d;
   end

   assign mem.resp         = mem_resp_c;
   assign mem.rdata        = data_q[req_index][hit_way];
   assign pmem.read        = pmem_read_q;
   assign pmem.write       = pmem_write_q;
   assign pmem.byte_enable = '1;
   assign pmem.wdata       = data_q[req_index][victim_q];
   assign pmem.address     = (state_q == WRITEBACK)
                           ? {tag_q[req_index][victim_q], req_index, {s_offset{1'b0}}}
                           : {req_tag, req_index, {s_offset{1'b0}}};

`ifdef CACHE_PERF_CTR_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic [31:0] wb_count_q, wb_count_d;

   always_comb begin
      hit_count_d  = hit_count_q + (hit_evt ? 32'd1 : 32'd0);
      miss_count_d = miss_count_q + (fill_evt ? 32'd1 : 32'd0);
      wb_count_d   = wb_count_q + (wb_evt ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
         wb_count_q   <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         wb_count_q   <= wb_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
   assign wb_count   = wb_count_q;
`else
   logic unused_evt;
   assign unused_evt = hit_evt | fill_evt | wb_evt;
   assign hit_count  = '0;
   assign miss_count = '0;
   assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed table-driven bench for set_assoc_cache with a small line-memory responder.
module tb_set_assoc_cache;
   import cache_pkg::*;

`ifdef CACHE_PERF_CTR_EN
   localparam bit CTR_EN = 1'b1;
`else
   localparam bit CTR_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic [31:0] hit_count, miss_count, wb_count;

   set_assoc_cache_if #(.s_mask(32)) cpu_if ();
   set_assoc_cache_if #(.s_mask(32)) pm_if ();

   set_assoc_cache #(
      .s_offset(5),
      .s_index (3),
      .s_ways  (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem       (cpu_if),
      .pmem      (pm_if),
      .hit_count (hit_count),
      .miss_count(miss_count),
      .wb_count  (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [31:0]  be;
      logic [255:0] wd;
      logic [255:0] exp_rd;
      int           exp_fills;
      int           exp_wbs;
      logic [31:0]  exp_first;
   } vec_t;

   vec_t vecs [18];

   logic [255:0] mem_model [logic [31:0]];

   int n_cmp = 0;
   int n_err = 0;

   logic [255:0] res_rd;
   int           res_fills, res_wbs;
   bit           res_lat_ok, res_done, both_seen;
   logic [31:0]  res_first, res_fill_addr;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] line_of(input logic [31:0] a);
      logic [7:0] pat;
      if (mem_model.exists(a)) return mem_model[a];
      pat = a[11:4];
      return {32{pat}};
   endfunction

   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] be,
                         input logic [255:0] wd);
      int  wait_n;
      bit  just_filled;
      bit  first_set;
      wait_n      = 0;
      just_filled = 1'b0;
      first_set   = 1'b0;
      res_fills   = 0;
      res_wbs     = 0;
      res_lat_ok  = 1'b0;
      res_done    = 1'b0;
      res_rd      = '0;
      res_first   = '0;
      res_fill_addr = '0;
      @(posedge clk);
      #1;
      cpu_if.read        = !wr;
      cpu_if.write       = wr;
      cpu_if.address     = addr;
      cpu_if.byte_enable = be;
      cpu_if.wdata       = wd;
      for (int cyc = 0; cyc < 100 && !res_done; cyc++) begin
         @(negedge clk);
         if (cpu_if.resp) begin
            res_rd     = cpu_if.rdata;
            res_lat_ok = (res_fills == 0) ? (cyc == 0) : just_filled;
            res_done   = 1'b1;
         end else begin
            just_filled = 1'b0;
            if (pm_if.read && pm_if.write) both_seen = 1'b1;
            if (pm_if.read || pm_if.write) begin
               wait_n++;
               if (wait_n == 2) begin
                  if (!first_set) begin
                     res_first = pm_if.address;
                     first_set = 1'b1;
                  end
                  if (pm_if.write) begin
                     res_wbs++;
                     mem_model[pm_if.address] = pm_if.wdata;
                  end else begin
                     res_fills++;
                     res_fill_addr = pm_if.address;
                     pm_if.rdata   = line_of(pm_if.address);
                     just_filled   = 1'b1;
                  end
                  pm_if.resp = 1'b1;
                  @(posedge clk);
                  #1;
                  pm_if.resp = 1'b0;
                  wait_n     = 0;
               end
            end
         end
      end
      if (!res_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL access timeout: addr %h got no mem_resp required one", addr);
      end
      @(posedge clk);
      #1;
      cpu_if.read  = 1'b0;
      cpu_if.write = 1'b0;
   endtask

   initial begin
      bit seen;
      vecs[0]  = '{0, 32'h040, '0, '0, {32{8'hA5}}, 1, 0, 32'h040};
      vecs[1]  = '{0, 32'h040, '0, '0, {32{8'hA5}}, 0, 0, 32'h0};
      vecs[2]  = '{1, 32'h040, 32'h0000000F, {32{8'h11}}, '0, 0, 0, 32'h0};
      vecs[3]  = '{0, 32'h040, '0, '0, {{28{8'hA5}}, {4{8'h11}}}, 0, 0, 32'h0};
      vecs[4]  = '{0, 32'h140, '0, '0, {32{8'h14}}, 1, 0, 32'h140};
      vecs[5]  = '{0, 32'h240, '0, '0, {32{8'h24}}, 1, 0, 32'h240};
      vecs[6]  = '{0, 32'h340, '0, '0, {32{8'h34}}, 1, 0, 32'h340};
      vecs[7]  = '{0, 32'h440, '0, '0, {32{8'h44}}, 1, 1, 32'h040};
      vecs[8]  = '{0, 32'h440, '0, '0, {32{8'h44}}, 0, 0, 32'h0};
      vecs[9]  = '{0, 32'h540, '0, '0, {32{8'h54}}, 1, 0, 32'h540};
      vecs[10] = '{0, 32'h140, '0, '0, {32{8'h14}}, 0, 0, 32'h0};
      vecs[11] = '{0, 32'h340, '0, '0, {32{8'h34}}, 0, 0, 32'h0};
      vecs[12] = '{0, 32'h240, '0, '0, {32{8'h24}}, 1, 0, 32'h240};
      vecs[13] = '{0, 32'h060, '0, '0, {32{8'h06}}, 1, 0, 32'h060};
      vecs[14] = '{1, 32'h060, 32'hF0000000, {32{8'h77}}, '0, 0, 0, 32'h0};
      vecs[15] = '{0, 32'h06C, '0, '0, {{4{8'h77}}, {28{8'h06}}}, 0, 0, 32'h0};
      vecs[16] = '{1, 32'h1A0, 32'h0000FF00, {32{8'hC3}}, '0, 1, 0, 32'h1A0};
      vecs[17] = '{0, 32'h1A0, '0, '0, {{16{8'h1A}}, {8{8'hC3}}, {8{8'h1A}}}, 0, 0, 32'h0};

      mem_model[32'h040] = {32{8'hA5}};
      both_seen          = 1'b0;
      rst_n              = 1'b0;
      cpu_if.read        = 1'b0;
      cpu_if.write       = 1'b0;
      cpu_if.address     = '0;
      cpu_if.byte_enable = '0;
      cpu_if.wdata       = '0;
      pm_if.rdata        = '0;
      pm_if.resp         = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset pmem_read", pm_if.read, 0);
      check("reset pmem_write", pm_if.write, 0);
      check("reset mem_resp", cpu_if.resp, 0);
      check("reset hit_count", hit_count, 0);
      check("reset miss_count", miss_count, 0);
      check("reset wb_count", wb_count, 0);

      for (int i = 0; i < 18; i++) begin
         access(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd);
         if (!vecs[i].wr) check($sformatf("v%0d rdata", i), res_rd, vecs[i].exp_rd);
         check($sformatf("v%0d fills", i), res_fills, vecs[i].exp_fills);
         check($sformatf("v%0d writebacks", i), res_wbs, vecs[i].exp_wbs);
         check($sformatf("v%0d resp timing", i), res_lat_ok, 1);
         if (vecs[i].exp_fills > 0) begin
            check($sformatf("v%0d first pmem addr", i), res_first, vecs[i].exp_first);
            check($sformatf("v%0d fill addr", i), res_fill_addr, vecs[i].addr & 32'hFFFF_FFE0);
         end
      end

      check("writeback line 0x40", line_of(32'h040), {{28{8'hA5}}, {4{8'h11}}});
      check("pmem read+write overlap", both_seen, 0);
      check("hit_count total", hit_count, CTR_EN ? 32'd18 : 32'd0);
      check("miss_count total", miss_count, CTR_EN ? 32'd9 : 32'd0);
      check("wb_count total", wb_count, CTR_EN ? 32'd1 : 32'd0);

      // Reset while the FILL request is outstanding.
      @(posedge clk);
      #1;
      cpu_if.read    = 1'b1;
      cpu_if.address = 32'h080;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = pm_if.read;
      end
      check("mid-fill pmem_read seen", seen, 1);
      rst_n = 1'b0;
      #1;
      check("mid-fill reset pmem_read", pm_if.read, 0);
      check("mid-fill reset pmem_write", pm_if.write, 0);
      check("mid-fill reset mem_resp", cpu_if.resp, 0);
      check("mid-fill reset miss_count", miss_count, 0);
      cpu_if.read = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      access(1'b0, 32'h080, '0, '0);
      check("post-reset 0x80 fills", res_fills, 1);
      check("post-reset 0x80 rdata", res_rd, {32{8'h08}});
      access(1'b0, 32'h040, '0, '0);
      check("post-reset 0x40 misses", res_fills, 1);
      check("post-reset 0x40 rdata", res_rd, {{28{8'hA5}}, {4{8'h11}}});
      check("post-reset hit_count", hit_count, CTR_EN ? 32'd2 : 32'd0);
      check("post-reset miss_count", miss_count, CTR_EN ? 32'd2 : 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
